// File: rtl/mul_bus_pkg.sv
// Shared types and constants for the multiplier bus initiator.
// States, bus phases, address map and phase decode helpers.
package mul_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    WR_A  = 2'd0,
    WR_B  = 2'd1,
    RD_LO = 2'd2,
    RD_HI = 2'd3
  } phase_t;

  localparam logic ADDR_LO = 1'b0;
  localparam logic ADDR_HI = 1'b1;

  function automatic logic phase_addr(phase_t p);
    return p[0] ? ADDR_HI : ADDR_LO;
  endfunction

  function automatic logic phase_wr(phase_t p);
    return !p[1];
  endfunction

endpackage

// File: rtl/mul_bus_timer.sv
// Loadable down-counter timing the low part of each bus strobe.
// Ports: clk, rst_n, load (restart at CYCLES), expire (last strobe cycle).
module mul_bus_timer #(
  parameter int unsigned CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic expire
);

  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= 4'(CYCLES);
    end else if (cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Counter sits at CYCLES in the first strobe cycle, so a value of
  // one marks the final strobe cycle.
  assign expire = (cnt == 4'd1);

endmodule

// File: rtl/mul_bus_master.sv
// Bus initiator: writes A and B, reads product low/high, pulses done.
// Ports: clk, rst_n, start, a, b, busy, done, product, bus cs/rd/wr/addr/dout/oe/din.
module mul_bus_master
  import mul_bus_pkg::*;
#(
  parameter int unsigned STROBE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product,
  output logic        cs_n,
  output logic        rd_n,
  output logic        wr_n,
  output logic        addr,
  output logic [7:0]  dout,
  output logic        dout_oe,
  input  logic [7:0]  din
);

  state_t state_q, state_d;
  phase_t phase_q, phase_d;

  logic [7:0] a_q, b_q;
  logic [7:0] lo_q, hi_q;
  logic       accept;
  logic       expire;
  logic       in_bus;
  logic       wr_ph;
  logic [7:0] op_a;

  logic        cs_n_d, rd_n_d, wr_n_d, addr_d;
  logic        oe_d, busy_d, done_d;
  logic [7:0]  dout_d;

  mul_bus_timer #(
    .CYCLES(STROBE_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (state_q == SETUP),
    .expire(expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      phase_q <= WR_A;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = SETUP;
          phase_d = WR_A;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP:  state_d = STROBE;
      STROBE: if (expire) state_d = HOLD;
      HOLD: begin
        if (phase_q == RD_HI) begin
          state_d = DONE;
        end else begin
          state_d = SETUP;
          phase_d = phase_t'(phase_q + 2'd1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so that the registered
  // bus pins line up with the state they belong to.
  always_comb begin
    in_bus = (state_d == SETUP) ||
             (state_d == STROBE) ||
             (state_d == HOLD);
    wr_ph  = phase_wr(phase_d);
    op_a   = accept ? a : a_q;
    cs_n_d = !in_bus;
    addr_d = in_bus ? phase_addr(phase_d) : ADDR_LO;
    oe_d   = in_bus && wr_ph;
    dout_d = 8'h00;
    if (oe_d) begin
      dout_d = (phase_d == WR_A) ? op_a : b_q;
    end
    wr_n_d = !((state_d == STROBE) && wr_ph);
    rd_n_d = !((state_d == STROBE) && !wr_ph);
    busy_d = in_bus;
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= 8'h00;
      b_q  <= 8'h00;
      lo_q <= 8'h00;
      hi_q <= 8'h00;
    end else begin
      if (accept) begin
        a_q <= a;
        b_q <= b;
      end
      if (state_q == STROBE && expire &&
          !phase_wr(phase_q)) begin
        if (phase_q[0]) hi_q <= din;
        else            lo_q <= din;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_n    <= 1'b1;
      rd_n    <= 1'b1;
      wr_n    <= 1'b1;
      addr    <= ADDR_LO;
      dout    <= 8'h00;
      dout_oe <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= 16'h0000;
    end else begin
      cs_n    <= cs_n_d;
      rd_n    <= rd_n_d;
      wr_n    <= wr_n_d;
      addr    <= addr_d;
      dout    <= dout_d;
      dout_oe <= oe_d;
      busy    <= busy_d;
      done    <= done_d;
      // Both shadows are final by the HOLD of RD_HI, so the product
      // updates as a whole word.
      if (state_q == HOLD && state_d == DONE) begin
        product <= {hi_q, lo_q};
      end
    end
  end

endmodule
